// File: rtl/input_sequencer.sv
// Captures one round of player colour presses, debouncing each press and
// comparing it against the stored sequence, with a per-press timeout.
module input_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int TIMEOUT_CYCLES  = 250_000_000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [5:0]       round_len,
   input  logic [32:0][1:0] segment,
   input  logic [3:0]       player_input,
   output logic             busy,
   output logic [5:0]       idx,
   output logic [1:0]       colour_o,
   output logic             colour_valid,
   output logic             pass,
   output logic             fail,
   output logic             timeout
);

   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_PRESS,
      DEBOUNCE,
      CHECK
   } state_t;

   state_t        state, state_next;
   logic [DW-1:0] deb_cnt, deb_cnt_next;
   logic [TW-1:0] to_cnt, to_cnt_next;
   logic [5:0]    idx_next;
   logic [5:0]    len_q, len_next;
   logic [3:0]    pattern_q, pattern_next;
   logic [1:0]    colour_q, colour_next;

   logic          press_valid;
   logic [1:0]    press_code;
   logic          start_ok;
   logic          colour_match;
   logic          last_colour;
   logic          to_expired;

   // Patterns with zero or several bits set are never a press.
   always_comb begin
      press_valid = 1'b1;
      press_code  = 2'd0;
      case (player_input)
         4'b0001: press_code = 2'd0;
         4'b0010: press_code = 2'd1;
         4'b0100: press_code = 2'd2;
         4'b1000: press_code = 2'd3;
         default: press_valid = 1'b0;
      endcase
   end

   assign start_ok     = start && (round_len != 6'd0) && (round_len <= 6'd33);
   assign colour_match = (segment[idx] == colour_q);
   assign last_colour  = (idx == len_q - 6'd1);
   assign to_expired   = (to_cnt == TO_LAST);

   always_comb begin
      state_next   = state;
      deb_cnt_next = deb_cnt;
      to_cnt_next  = to_cnt;
      idx_next     = idx;
      len_next     = len_q;
      pattern_next = pattern_q;
      colour_next  = colour_q;
      case (state)
         IDLE: begin
            if (start_ok) begin
               state_next   = ARM;
               idx_next     = 6'd0;
               len_next     = round_len;
               deb_cnt_next = '0;
            end
         end
         ARM: begin
            if (player_input != 4'd0) begin
               deb_cnt_next = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_next   = WAIT_PRESS;
               deb_cnt_next = '0;
               to_cnt_next  = '0;
            end else begin
               deb_cnt_next = deb_cnt + DW'(1);
            end
         end
         WAIT_PRESS: begin
            if (to_expired) begin
               state_next = IDLE;
            end else begin
               to_cnt_next = to_cnt + TW'(1);
               if (press_valid) begin
                  pattern_next = player_input;
                  deb_cnt_next = '0;
                  state_next   = DEBOUNCE;
               end
            end
         end
         // Timeout is tested first so it wins over a simultaneous CHECK entry.
         DEBOUNCE: begin
            if (to_expired) begin
               state_next = IDLE;
            end else begin
               to_cnt_next = to_cnt + TW'(1);
               if (player_input != pattern_q) begin
                  state_next = WAIT_PRESS;
               end else if (deb_cnt == DEB_LAST) begin
                  state_next  = CHECK;
                  colour_next = press_code;
               end else begin
                  deb_cnt_next = deb_cnt + DW'(1);
               end
            end
         end
         CHECK: begin
            if (!colour_match || last_colour) begin
               state_next = IDLE;
            end else begin
               idx_next     = idx + 6'd1;
               deb_cnt_next = '0;
               state_next   = ARM;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         deb_cnt   <= '0;
         to_cnt    <= '0;
         idx       <= 6'd0;
         len_q     <= 6'd0;
         pattern_q <= 4'd0;
         colour_q  <= 2'd0;
      end else begin
         state     <= state_next;
         deb_cnt   <= deb_cnt_next;
         to_cnt    <= to_cnt_next;
         idx       <= idx_next;
         len_q     <= len_next;
         pattern_q <= pattern_next;
         colour_q  <= colour_next;
      end
   end

   // Result strobes are gated by reset so an abandoned round never reports.
   assign busy         = (state != IDLE);
   assign colour_o     = colour_q;
   assign colour_valid = (state == CHECK) && !reset;
   assign pass         = (state == CHECK) && colour_match && last_colour && !reset;
   assign fail         = (state == CHECK) && !colour_match && !reset;
   assign timeout      = ((state == WAIT_PRESS) || (state == DEBOUNCE)) && to_expired && !reset;

endmodule

// File: tb/tb_input_sequencer.sv
// Directed bench for input_sequencer: a cycle-by-cycle vector table plus
// hand-written multi-cycle rounds for debounce, timeout and reset corners.
module tb_input_sequencer;

   localparam int DEB = 4;
   localparam int TO  = 64;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [5:0]       round_len;
   logic [32:0][1:0] segment;
   logic [3:0]       player_input;
   logic             busy;
   logic [5:0]       idx;
   logic [1:0]       colour_o;
   logic             colour_valid;
   logic             pass;
   logic             fail;
   logic             timeout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rst;
      logic        st;
      logic [5:0]  len;
      logic [3:0]  pin;
      logic [12:0] exp_out;
   } vec_t;

   vec_t vecs[16];

   always #5 clk = ~clk;

   input_sequencer #(
      .DEBOUNCE_CYCLES(DEB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .round_len   (round_len),
      .segment     (segment),
      .player_input(player_input),
      .busy        (busy),
      .idx         (idx),
      .colour_o    (colour_o),
      .colour_valid(colour_valid),
      .pass        (pass),
      .fail        (fail),
      .timeout     (timeout)
   );

   function automatic logic [12:0] pack_out(input logic b, input logic [5:0] i, input logic cv,
                                            input logic [1:0] co, input logic p, input logic f,
                                            input logic t);
      return {b, i, cv, co, p, f, t};
   endfunction

   function automatic vec_t make_vec(input logic rst, input logic st, input logic [5:0] len,
                                     input logic [3:0] pin, input logic [12:0] e);
      vec_t v;
      v.rst     = rst;
      v.st      = st;
      v.len     = len;
      v.pin     = pin;
      v.exp_out = e;
      return v;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Drives one cycle's inputs just after the rising edge, returns mid-cycle.
   task automatic apply_stimulus(input logic rst, input logic st, input logic [5:0] len,
                                 input logic [3:0] pin);
      @(posedge clk);
      #1;
      reset        = rst;
      start        = st;
      round_len    = len;
      player_input = pin;
      @(negedge clk);
   endtask

   // Leaves the DUT so the next apply_stimulus is the first WAIT_PRESS cycle.
   task automatic start_round(input logic [5:0] len);
      apply_stimulus(1'b0, 1'b1, len, 4'd0);
      for (int k = 0; k < DEB; k++) apply_stimulus(1'b0, 1'b0, 6'd0, 4'd0);
   endtask

   initial begin
      int        strobes;
      int        pass_cnt;
      int        fail_cnt;
      int        to_cnt;
      int        first_cv;
      int        first_to;
      int        pass_strobe;
      logic      busy_63;
      logic [1:0] got_co[3];
      logic [5:0] got_idx[3];
      logic [3:0] pats[3];
      logic [3:0] pin;

      reset        = 1'b1;
      start        = 1'b0;
      round_len    = 6'd0;
      player_input = 4'd0;
      segment      = '0;

      // Table: short failing round plus start qualification corners.
      segment[0] = 2'd1;
      vecs[0]  = make_vec(1, 0, 6'd0,  4'b0000, pack_out(0, 0, 0, 0, 0, 0, 0));
      vecs[1]  = make_vec(1, 1, 6'd3,  4'b0000, pack_out(0, 0, 0, 0, 0, 0, 0));
      vecs[2]  = make_vec(0, 1, 6'd0,  4'b0000, pack_out(0, 0, 0, 0, 0, 0, 0));
      vecs[3]  = make_vec(0, 1, 6'd34, 4'b0000, pack_out(0, 0, 0, 0, 0, 0, 0));
      vecs[4]  = make_vec(0, 1, 6'd1,  4'b0000, pack_out(0, 0, 0, 0, 0, 0, 0));
      vecs[5]  = make_vec(0, 1, 6'd5,  4'b0000, pack_out(1, 0, 0, 0, 0, 0, 0));
      vecs[6]  = make_vec(0, 0, 6'd0,  4'b0000, pack_out(1, 0, 0, 0, 0, 0, 0));
      vecs[7]  = make_vec(0, 0, 6'd0,  4'b0000, pack_out(1, 0, 0, 0, 0, 0, 0));
      vecs[8]  = make_vec(0, 0, 6'd0,  4'b0000, pack_out(1, 0, 0, 0, 0, 0, 0));
      vecs[9]  = make_vec(0, 0, 6'd0,  4'b0100, pack_out(1, 0, 0, 0, 0, 0, 0));
      vecs[10] = make_vec(0, 0, 6'd0,  4'b0100, pack_out(1, 0, 0, 0, 0, 0, 0));
      vecs[11] = make_vec(0, 0, 6'd0,  4'b0100, pack_out(1, 0, 0, 0, 0, 0, 0));
      vecs[12] = make_vec(0, 0, 6'd0,  4'b0100, pack_out(1, 0, 0, 0, 0, 0, 0));
      vecs[13] = make_vec(0, 0, 6'd0,  4'b0100, pack_out(1, 0, 0, 0, 0, 0, 0));
      vecs[14] = make_vec(0, 0, 6'd0,  4'b0100, pack_out(1, 0, 1, 2, 0, 1, 0));
      vecs[15] = make_vec(0, 0, 6'd0,  4'b0100, pack_out(0, 0, 0, 2, 0, 0, 0));

      apply_stimulus(1'b1, 1'b0, 6'd0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         apply_stimulus(vecs[i].rst, vecs[i].st, vecs[i].len, vecs[i].pin);
         check_output($sformatf("vec%0d", i),
                      {19'd0, busy, idx, colour_valid, colour_o, pass, fail, timeout},
                      {19'd0, vecs[i].exp_out});
      end

      // Three-colour passing round.
      apply_stimulus(1'b1, 1'b0, 6'd0, 4'd0);
      segment    = '0;
      segment[0] = 2'd2;
      segment[1] = 2'd0;
      segment[2] = 2'd3;
      pats[0] = 4'b0100;
      pats[1] = 4'b0001;
      pats[2] = 4'b1000;
      strobes = 0; pass_cnt = 0; fail_cnt = 0; pass_strobe = -1;
      start_round(6'd3);
      for (int k = 0; k < 3; k++) begin
         for (int c = 0; c < 12; c++) begin
            apply_stimulus(1'b0, 1'b0, 6'd0, (c < 6) ? pats[k] : 4'd0);
            if (colour_valid) begin
               if (strobes < 3) begin
                  got_co[strobes]  = colour_o;
                  got_idx[strobes] = idx;
               end
               if (pass) pass_strobe = strobes;
               strobes++;
            end
            if (pass) pass_cnt++;
            if (fail) fail_cnt++;
         end
      end
      check_output("seq3_strobes", strobes, 3);
      check_output("seq3_colour0", got_co[0], 2);
      check_output("seq3_colour1", got_co[1], 0);
      check_output("seq3_colour2", got_co[2], 3);
      check_output("seq3_idx", {got_idx[0], got_idx[1], got_idx[2]}, {6'd0, 6'd1, 6'd2});
      check_output("seq3_pass_count", pass_cnt, 1);
      check_output("seq3_pass_strobe", pass_strobe, 2);
      check_output("seq3_fail_count", fail_cnt, 0);
      check_output("seq3_busy_after", busy, 0);
      check_output("seq3_idx_hold", idx, 2);

      // Bouncing press: only the final stable run is accepted.
      apply_stimulus(1'b1, 1'b0, 6'd0, 4'd0);
      segment    = '0;
      segment[0] = 2'd1;
      strobes = 0; first_cv = -1; pass_cnt = 0;
      got_co[0] = 2'd0;
      start_round(6'd1);
      for (int k = 0; k < 20; k++) begin
         pin = (k >= 10 || (k % 4) < 2) ? 4'b0010 : 4'b0000;
         apply_stimulus(1'b0, 1'b0, 6'd0, pin);
         if (colour_valid) begin
            strobes++;
            if (first_cv < 0) begin
               first_cv  = k;
               got_co[0] = colour_o;
            end
            if (pass) pass_cnt++;
         end
      end
      check_output("bounce_strobes", strobes, 1);
      check_output("bounce_cv_cycle", first_cv, 13);
      check_output("bounce_colour", got_co[0], 1);
      check_output("bounce_pass", pass_cnt, 1);

      // Invalid two-bit press never registers; the round times out.
      apply_stimulus(1'b1, 1'b0, 6'd0, 4'd0);
      strobes = 0; first_to = -1; to_cnt = 0; pass_cnt = 0; fail_cnt = 0; busy_63 = 1'b0;
      start_round(6'd1);
      for (int j = 0; j < 70; j++) begin
         apply_stimulus(1'b0, 1'b0, 6'd0, (j < 20) ? 4'b0011 : 4'b0000);
         if (colour_valid) strobes++;
         if (pass) pass_cnt++;
         if (fail) fail_cnt++;
         if (timeout) begin
            to_cnt++;
            if (first_to < 0) first_to = j;
         end
         if (j == 63) busy_63 = busy;
      end
      check_output("tmo_cycle", first_to, 63);
      check_output("tmo_count", to_cnt, 1);
      check_output("tmo_no_strobe", strobes + pass_cnt + fail_cnt, 0);
      check_output("tmo_busy_at_pulse", busy_63, 1);
      check_output("tmo_busy_after", busy, 0);

      // Timeout expiring in the cycle that would otherwise enter CHECK.
      apply_stimulus(1'b1, 1'b0, 6'd0, 4'd0);
      segment = '0;
      strobes = 0; first_to = -1; to_cnt = 0; pass_cnt = 0;
      start_round(6'd1);
      for (int j = 0; j < 70; j++) begin
         apply_stimulus(1'b0, 1'b0, 6'd0, (j >= 59) ? 4'b0001 : 4'b0000);
         if (colour_valid) strobes++;
         if (pass) pass_cnt++;
         if (timeout) begin
            to_cnt++;
            if (first_to < 0) first_to = j;
         end
      end
      check_output("race_tmo_cycle", first_to, 63);
      check_output("race_tmo_count", to_cnt, 1);
      check_output("race_no_check", strobes + pass_cnt, 0);

      // Reset during the second colour's debounce abandons the round.
      apply_stimulus(1'b1, 1'b0, 6'd0, 4'd0);
      segment    = '0;
      segment[0] = 2'd1;
      segment[1] = 2'd3;
      start_round(6'd2);
      for (int c = 0; c < 12; c++) apply_stimulus(1'b0, 1'b0, 6'd0, (c < 6) ? 4'b0010 : 4'b0000);
      for (int c = 0; c < 3; c++) apply_stimulus(1'b0, 1'b0, 6'd0, 4'b1000);
      check_output("rst_idx_before", idx, 1);
      pass_cnt = 0; fail_cnt = 0; to_cnt = 0; strobes = 0;
      apply_stimulus(1'b1, 1'b0, 6'd0, 4'b1000);
      if (pass) pass_cnt++;
      if (fail) fail_cnt++;
      if (timeout) to_cnt++;
      apply_stimulus(1'b0, 1'b0, 6'd0, 4'b1000);
      check_output("rst_busy_idx", {busy, idx}, {1'b0, 6'd0});
      for (int c = 0; c < 8; c++) begin
         apply_stimulus(1'b0, 1'b0, 6'd0, 4'b1000);
         if (colour_valid) strobes++;
         if (pass) pass_cnt++;
         if (fail) fail_cnt++;
         if (timeout) to_cnt++;
      end
      check_output("rst_no_result", pass_cnt + fail_cnt + to_cnt + strobes, 0);
      apply_stimulus(1'b0, 1'b1, 6'd0, 4'b0000);
      apply_stimulus(1'b0, 1'b0, 6'd0, 4'b0000);
      check_output("len0_ignored", busy, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/input_sequencer.md
INPUT_SEQUENCER -- requirements
Module: input_sequencer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500_000, cycles an input pattern must be stable before it is accepted (10 ms at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 250_000_000, maximum cycles spent waiting for a press (5 s at 50 MHz).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin capturing one round.
REQ-006 SHALL have port round_len  input  6  number of colours expected this round, legal 1..33, sampled on accepted start.
REQ-007 SHALL have port segment  input  33x2  stored colour sequence; entry 0 is the first colour.
REQ-008 SHALL have port player_input  input  4  raw switches, active-high; bit n = colour n.
REQ-009 SHALL have port busy  output  1  high from accepted start until the round terminates.
REQ-010 SHALL have port idx  output  6  index of the colour currently expected.
REQ-011 SHALL have ports colour_o (output, 2) and colour_valid (output, 1): accepted colour and its one-cycle strobe.
REQ-012 SHALL have ports pass, fail, timeout  output  1 each  one-cycle round-result pulses.

Function
REQ-013 SHALL decode player_input as: exactly one bit set = press of colour n; all zero = released; more than one bit set = invalid, treated as no press.
REQ-014 SHALL implement states IDLE, ARM, WAIT_PRESS, DEBOUNCE and CHECK.
REQ-015 IDLE: SHALL hold busy=0; start with round_len in 1..33 SHALL set idx=0, latch round_len, and enter ARM next cycle; start with round_len 0 or >33 SHALL be ignored.
REQ-016 ARM: SHALL require player_input==0 for DEBOUNCE_CYCLES consecutive cycles, restarting the count on any nonzero sample, then enter WAIT_PRESS.
REQ-017 WAIT_PRESS: a valid one-hot press SHALL latch its pattern, clear the debounce counter, and enter DEBOUNCE.
REQ-018 DEBOUNCE: if player_input differs from the latched pattern, SHALL return to WAIT_PRESS; after DEBOUNCE_CYCLES consecutive matching cycles, SHALL enter CHECK.
REQ-019 CHECK (one cycle): SHALL assert colour_valid with colour_o = encoded press and compare it against segment[idx].
REQ-020 On mismatch in CHECK, SHALL pulse fail in the same cycle and go to IDLE.
REQ-021 On match with idx==round_len-1, SHALL pulse pass in the same cycle and go to IDLE.
REQ-022 On any other match, SHALL increment idx and go to ARM (the switch must be released before the next press).
REQ-023 Timeout counter: SHALL clear on entry to WAIT_PRESS from ARM and count in WAIT_PRESS and DEBOUNCE without clearing on bounce.
REQ-024 On reaching TIMEOUT_CYCLES-1, SHALL pulse timeout and go to IDLE; if it expires in the same cycle CHECK would be entered, timeout SHALL win.
REQ-025 start SHALL be ignored while busy=1.
REQ-026 pass, fail, timeout and colour_valid SHALL each be high for exactly one cycle; at most one of pass, fail and timeout SHALL fire per round.
REQ-027 idx SHALL never exceed 32 and SHALL hold its value after termination until the next accepted start.
REQ-028 Latency from the first stable press cycle to colour_valid SHALL be DEBOUNCE_CYCLES+1 cycles.

Reset
REQ-029 reset SHALL override all other inputs, including start in the same cycle.
REQ-030 reset SHALL force state=IDLE, busy=0, idx=0, colour_o=0, colour_valid=0, pass=0, fail=0, timeout=0, and clear all counters.
REQ-031 reset mid-round SHALL abandon the round with no result pulse.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-032 segment[0..2]={2,0,3}, round_len=3, start; release then press 0100, 0001 and 1000, each held 6 cycles with releases in between -> three colour_valid strobes with colour_o 2, 0, 3; pass on the third; fail never asserted.
REQ-033 segment[0]=1, round_len=1; press 0100 -> colour_valid with colour_o=2 and fail in the same cycle; busy drops the next cycle.
REQ-034 Press 0010 toggling every 2 cycles for 10 cycles, then held -> no colour_valid until 4 stable cycles; colour_o=1.
REQ-035 Press 0011 held for 20 cycles -> no colour_valid; timeout pulses 64 cycles after WAIT_PRESS entry.
REQ-036 Assert reset during DEBOUNCE -> next cycle busy=0 and idx=0, with no pass, fail or timeout pulse; start with round_len=0 -> busy stays 0.
